// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Handshake/status bundle between the TX buffer, the line
//               control registers and the UART transmit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
    logic       baud_en;        // 16x baud enable pulse
    logic [7:0] tx_data;        // head-of-buffer character
    logic       tx_fifo_empty;  // TX buffer empty
    logic [1:0] wls;            // word length select
    logic       stb;            // stop bit select
    logic       pen;            // parity enable
    logic       eps;            // even parity select
    logic       sp;             // stick parity
    logic       bc;             // break control
    logic       tsr_load;       // pop strobe to TX buffer
    logic       txd;            // serial output
    logic       tsr_empty;      // transmitter empty
    logic       tx_busy;        // frame in progress

    // Buffer / register side
    modport master (
        output baud_en, tx_data, tx_fifo_empty, wls, stb, pen, eps, sp, bc,
        input  tsr_load, txd, tsr_empty, tx_busy
    );

    // Serializer side
    modport slave (
        input  baud_en, tx_data, tx_fifo_empty, wls, stb, pen, eps, sp, bc,
        output tsr_load, txd, tsr_empty, tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit shift register and framing engine. Pops one
//               character from the TX buffer and sends start, 5-8 data bits
//               LSB first, optional parity and 1/1.5/2 stop bits on txd.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    uart_tx_serializer_if.slave bus
);

    // Tick counter must reach 2*OVERSAMPLE-1 for the two-stop-bit case.
    localparam int c_tick_w = $clog2(2 * OVERSAMPLE);
    localparam logic [c_tick_w-1:0] c_bit_last    = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_stop15_last = c_tick_w'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [c_tick_w-1:0] c_stop2_last  = c_tick_w'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_tick_w-1:0] r_tick;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_txd;
    logic [1:0]          r_wls;
    logic                r_stb;
    logic                r_pen;
    logic                r_par;

    logic [7:0]          w_mask;
    logic [7:0]          w_masked;
    logic                w_par;
    logic [2:0]          w_bit_last;
    logic [c_tick_w-1:0] w_stop_last;
    logic                w_tick_done;

    // Character masking, parity and per-state bit length from the latched frame setup.
    always_comb begin
        w_mask = 8'hFF;
        case (bus.wls)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
        w_masked    = bus.tx_data & w_mask;
        // Stick parity sends ~eps; otherwise even = XOR of data, odd = its inverse.
        w_par       = bus.sp ? ~bus.eps : (bus.eps ? ^w_masked : ~(^w_masked));
        w_bit_last  = {1'b0, r_wls} + 3'd4;
        w_stop_last = !r_stb ? c_bit_last :
                      (r_wls == 2'b00) ? c_stop15_last : c_stop2_last;
        w_tick_done = bus.baud_en &&
                      (r_tick == ((r_state == S_STOP) ? w_stop_last : c_bit_last));
    end

    // Frame sequencer: state, tick/bit counters, shift register and registered line level.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_wls   <= '0;
            r_stb   <= 1'b0;
            r_pen   <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.tx_fifo_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift <= w_masked;
                    r_wls   <= bus.wls;
                    r_stb   <= bus.stb;
                    r_pen   <= bus.pen;
                    r_par   <= w_par;
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_txd   <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_tick_done) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else if (bus.baud_en) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick_done) begin
                        r_tick <= '0;
                        if (r_bit == w_bit_last) begin
                            r_txd   <= r_pen ? r_par : 1'b1;
                            r_state <= r_pen ? S_PARITY : S_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else if (bus.baud_en) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick_done) begin
                        r_tick  <= '0;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else if (bus.baud_en) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_STOP: begin
                    // Back-to-back frames go straight to LOAD: a single pclk gap.
                    if (w_tick_done) begin
                        r_tick  <= '0;
                        r_state <= bus.tx_fifo_empty ? S_IDLE : S_LOAD;
                    end else if (bus.baud_en) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // Break forces the line low without disturbing the running frame.
    assign bus.txd       = r_txd & ~bus.bc;
    assign bus.tsr_load  = (r_state == S_LOAD);
    assign bus.tx_busy   = (r_state == S_START) || (r_state == S_DATA) ||
                           (r_state == S_PARITY) || (r_state == S_STOP);
    assign bus.tsr_empty = (r_state == S_IDLE) && bus.tx_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer. A frame monitor
//               samples txd on every baud pulse and compares each frame with
//               the expected record queued when the character was offered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       sp;
        logic       exp_par;
        int         exp_stop;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_serializer_if bus ();

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .pclk   (clk),
        .preset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   checks  = 0;
    int   errors  = 0;
    int   n_loads = 0;
    int   npulse  = 0;
    int   n_frame = 0;
    bit   in_frame = 1'b0;
    bit   mon_en   = 1'b1;
    logic samp [256];
    logic brk  [256];
    vec_t exp_q [$];
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare a completed frame against the oldest expected record.
    task automatic finish_frame();
        vec_t v;
        int   n, nb, total, lo, hi;
        logic lvl;
        bit   ok;
        n_frame++;
        if (exp_q.size() == 0) begin
            check($sformatf("frame%0d_unexpected", n_frame), 1, 0);
            return;
        end
        v     = exp_q.pop_front();
        n     = int'(v.wls) + 5;
        nb    = 1 + n + (v.pen ? 1 : 0);
        total = nb * OS + v.exp_stop;
        check($sformatf("frame%0d_len_pulses", n_frame), npulse, total);
        for (int k = 0; k <= nb; k++) begin
            lo = k * OS;
            hi = (k == nb) ? total : lo + OS;
            if (k == 0)       lvl = 1'b0;
            else if (k == nb) lvl = 1'b1;
            else if (k <= n)  lvl = v.data[k-1];
            else              lvl = v.exp_par;
            ok = 1'b1;
            for (int p = lo; p < hi; p++) begin
                if (p >= npulse || p >= 256) ok = 1'b0;
                else if (samp[p] !== (brk[p] ? 1'b0 : lvl)) ok = 1'b0;
            end
            check($sformatf("frame%0d_bit%0d", n_frame, k), ok, 1);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (bus.tsr_load) begin
                n_loads++;
                check("load_while_empty", bus.tx_fifo_empty, 0);
            end
            if (!mon_en) begin
                in_frame = 1'b0;
            end else if (bus.tx_busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    npulse   = 0;
                end
                if (bus.baud_en && npulse < 256) begin
                    samp[npulse] = bus.txd;
                    brk[npulse]  = bus.bc;
                    npulse++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                finish_frame();
            end
        end
    endtask

    // Baud enable: one pclk high out of every three.
    initial begin
        int bcnt;
        bcnt = 0;
        bus.baud_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bcnt = (bcnt == 2) ? 0 : bcnt + 1;
            bus.baud_en = (bcnt == 0);
        end
    end

    task automatic wait_load(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tsr_load) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1);
    endtask

    // Offer one character from IDLE, pop it, then scramble the setup.
    task automatic send_char(input vec_t v);
        @(posedge clk);
        #1;
        bus.tx_data = v.data; bus.wls = v.wls; bus.stb = v.stb;
        bus.pen = v.pen; bus.eps = v.eps; bus.sp = v.sp;
        bus.tx_fifo_empty = 1'b0;
        exp_q.push_back(v);
        #1;
        check("tsr_empty_falls", bus.tsr_empty, 0);
        wait_load("load_seen");
        @(posedge clk);
        #1;
        bus.tx_fifo_empty = 1'b1;
        bus.tx_data = ~v.data; bus.wls = ~v.wls; bus.stb = ~v.stb;
        bus.pen = ~v.pen; bus.eps = ~v.eps; bus.sp = ~v.sp;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.tx_busy && !in_frame && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("frame_done_timeout", done, 1);
        check("tsr_empty_after", bus.tsr_empty, 1);
        check("txd_idle_after", bus.txd, 1);
    endtask

    task automatic wait_pulses(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n * 10 && c < n; i++) begin
            @(negedge clk);
            if (bus.baud_en && bus.tx_busy) c++;
        end
        check("pulse_wait", c, n);
    endtask

    initial begin
        vec_t v;
        int   base;
        int   c;
        bit   ok;
        bit   got;
        bit   prev_busy;

        //           data   wls    stb   pen   eps   sp    par  stop
        vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};
        vecs[1] = '{8'h03, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16};
        vecs[2] = '{8'h03, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16};
        vecs[3] = '{8'h03, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16};
        vecs[4] = '{8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24};
        vecs[5] = '{8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32};
        vecs[6] = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32};
        vecs[7] = '{8'hE7, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16};
        vecs[8] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16};
        vecs[9] = '{8'h1A, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24};

        bus.tx_data = 8'h00; bus.tx_fifo_empty = 1'b1; bus.wls = 2'b11;
        bus.stb = 1'b0; bus.pen = 1'b0; bus.eps = 1'b0; bus.sp = 1'b0; bus.bc = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        @(negedge clk);
        check("rst_txd", bus.txd, 1);
        check("rst_tsr_load", bus.tsr_load, 0);
        check("rst_tsr_empty", bus.tsr_empty, 1);
        check("rst_tx_busy", bus.tx_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_txd", bus.txd, 1);
        check("idle_tsr_empty", bus.tsr_empty, 1);

        // Single frames from the vector table
        for (int i = 0; i < 10; i++) begin
            base = n_loads;
            send_char(vecs[i]);
            wait_done();
            check($sformatf("vec%0d_load_count", i), n_loads - base, 1);
        end

        // Back-to-back characters: one pclk LOAD gap between frames
        base = n_loads;
        @(posedge clk);
        #1;
        v = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};
        bus.tx_data = v.data; bus.wls = v.wls; bus.stb = v.stb;
        bus.pen = v.pen; bus.eps = v.eps; bus.sp = v.sp;
        bus.tx_fifo_empty = 1'b0;
        exp_q.push_back(v);
        wait_load("b2b_load1");
        @(posedge clk);
        #1;
        v.data = 8'h0F;
        bus.tx_data = v.data;
        exp_q.push_back(v);
        got = 1'b0;
        prev_busy = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.tsr_load) begin
                got = 1'b1;
                break;
            end
            prev_busy = bus.tx_busy;
        end
        check("b2b_load2", got, 1);
        check("b2b_stop_then_load", prev_busy, 1);
        check("b2b_load_txd", bus.txd, 1);
        check("b2b_load_busy", bus.tx_busy, 0);
        @(posedge clk);
        #1;
        bus.tx_fifo_empty = 1'b1;
        @(negedge clk);
        check("b2b_start_txd", bus.txd, 0);
        check("b2b_start_busy", bus.tx_busy, 1);
        wait_done();
        check("b2b_load_count", n_loads - base, 2);

        // Break for 40 baud pulses in the middle of DATA
        send_char(vecs[0]);
        wait_pulses(20);
        @(posedge clk);
        #1;
        bus.bc = 1'b1;
        ok = 1'b1;
        c = 0;
        for (int i = 0; i < 400 && c < 40; i++) begin
            @(negedge clk);
            if (bus.txd !== 1'b0) ok = 1'b0;
            if (bus.baud_en) c++;
        end
        check("break_txd_low", ok, 1);
        check("break_pulses", c, 40);
        @(posedge clk);
        #1;
        bus.bc = 1'b0;
        #1;
        check("break_busy_kept", bus.tx_busy, 1);
        wait_done();

        // Asynchronous reset during data bit 3 of 8'hA5 (bit value 0)
        send_char(vecs[0]);
        wait_pulses(70);
        @(posedge clk);
        #3;
        check("pre_reset_txd", bus.txd, 0);
        mon_en = 1'b0;
        in_frame = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("async_rst_txd", bus.txd, 1);
        check("async_rst_busy", bus.tx_busy, 0);
        check("async_rst_tsr_empty", bus.tsr_empty, 1);
        repeat (2) @(posedge clk);
        #1;
        v = '{8'h5A, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16};
        bus.tx_data = v.data; bus.wls = v.wls; bus.stb = v.stb;
        bus.pen = v.pen; bus.eps = v.eps; bus.sp = v.sp;
        bus.tx_fifo_empty = 1'b0;
        @(negedge clk);
        check("rst_hold_txd", bus.txd, 1);
        check("rst_hold_no_load", bus.tsr_load, 0);
        @(posedge clk);
        #1;
        base = n_loads;
        rst = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back(v);
        wait_load("post_reset_load");
        @(posedge clk);
        #1;
        bus.tx_fifo_empty = 1'b1;
        wait_done();
        check("post_reset_load_count", n_loads - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit shift register (TSR) and framing engine for the UART.
- Pops one character from the TX buffer (FIFO or THR) and serialises it on txd: start bit, 5–8 data bits (LSB first), optional parity, then 1, 1.5 or 2 stop bits.
- Timed by the 16x baud enable from the baud generator.
- Drives the TX buffer's read enable (tsr_load) and the transmitter-empty status to the line status logic.

Parameters:
- OVERSAMPLE, 16, baud enable pulses per bit time. Must be even and ≥ 4.

Ports:
- pclk  input  1  system clock.
- preset  input  1  asynchronous, active-high reset.
- baud_en  input  1  one-pclk pulse at 16x baud rate.
- tx_data  input  8  head-of-buffer character; valid whenever tx_fifo_empty=0.
- tx_fifo_empty  input  1  TX buffer empty.
- wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 bits.
- stb  input  1  stop bits: 0=1 stop; 1=2 stop (1.5 when wls=00).
- pen  input  1  parity enable.
- eps  input  1  even parity select.
- sp  input  1  stick parity.
- bc  input  1  break control; forces txd low.
- tsr_load  output  1  one-pclk pop strobe to TX buffer.
- txd  output  1  serial output, idle high.
- tsr_empty  output  1  TEMT: no frame in progress and no load pending.
- tx_busy  output  1  frame in progress (START through STOP).

Behaviour:
- Reset values (asynchronous, immediate on preset=1):
  - txd=1, tsr_load=0, tsr_empty=1, tx_busy=0.
  - state=IDLE; bit counter, tick counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; txd returns high with no truncated stop bit.
- States:
  - IDLE: if tx_fifo_empty=0, go to LOAD.
  - LOAD: lasts one pclk.
    - tsr_load=1.
    - Shift register ← tx_data.
    - wls, stb, pen, eps and sp are latched into frame registers.
    - Unused upper data bits are masked to 0.
    - Next state is START.
  - START: txd=0 for OVERSAMPLE baud_en pulses.
  - DATA: shifts out N=wls+5 bits, LSB first, each OVERSAMPLE pulses.
  - PARITY: entered only if latched pen=1; one bit time.
  - STOP: txd=1. Length is OVERSAMPLE pulses; 2*OVERSAMPLE if stb=1 and wls≠00; 3*OVERSAMPLE/2 if stb=1 and wls=00.
  - At end of STOP: go to LOAD if tx_fifo_empty=0, else IDLE.
- Timing and counters:
  - Transitions occur in the cycle of the terminating baud_en pulse.
  - The tick counter resets to 0 at each state entry.
  - txd is registered: it changes on the clock edge following the state transition.
  - txd goes low the cycle after the LOAD cycle.
  - The first start-bit tick is counted on the first baud_en at or after START entry, so start-bit length is OVERSAMPLE pulses ± one baud_en period of alignment.
  - Back-to-back frames: the gap between the end of stop and the next start is exactly one pclk (the LOAD cycle). No extra idle bit.
- Parity, computed over the N masked data bits (D = XOR of those bits):
  - pen=0: no parity bit.
  - sp=0, eps=0 (odd): bit = ~D.
  - sp=0, eps=1 (even): bit = D.
  - sp=1, eps=0: bit = 1.
  - sp=1, eps=1: bit = 0.
- Configuration changes while tx_busy=1 do not affect the current frame; they apply from the next LOAD.
- Break (bc=1):
  - txd=0 combinationally overrides the registered value.
  - The state machine keeps running, so characters are consumed and lost.
  - On release, txd resumes the current registered bit.
- Status outputs:
  - tx_busy=1 in START, DATA, PARITY and STOP.
  - tsr_empty=1 only when in IDLE and tx_fifo_empty=1.
  - tsr_empty falls in the cycle tx_fifo_empty falls while in IDLE.
- tsr_load is never asserted when tx_fifo_empty=1, and never more than once per frame.
- baud_en is ignored while in IDLE or LOAD.

Test Plan:
- Reset, then tx_data=8'hA5, wls=11, pen=0, stb=0, with one cycle of tx_fifo_empty=0. Required:
  - tsr_load pulses once.
  - txd sequence is 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 baud_en pulses.
  - tsr_empty returns to 1 after stop.
- 8'h03, wls=11, pen=1, eps=1, sp=0 → parity bit 0. Same frame with eps=0 → parity bit 1. With sp=1, eps=0 → parity bit 1 regardless of data.
- 8'hFF, wls=00, stb=1 → 5 data bits of 1, then stop high for 24 pulses. wls=11, stb=1 → stop lasts 32 pulses.
- Two characters 8'h55 and 8'h0F queued, tx_fifo_empty deasserted only after the second pop. Required:
  - Exactly two tsr_load pulses.
  - Second start bit begins one pclk after the first stop bit ends.
- bc=1 asserted mid-DATA for 40 pulses → txd=0 throughout. After release, txd matches the expected bit position of the ongoing frame and tx_busy is unaffected.
- preset asserted during bit 3 of DATA → txd=1, tx_busy=0 and tsr_empty=1 without waiting for a clock edge. After release with tx_fifo_empty=0, a fresh frame starts with tsr_load.
